// File: rtl/mem_pkg.sv
// Shared types and helpers for the valid/ready memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Read data returned for out-of-range requests when fault reporting is built in
    localparam logic [31:0] OOR_RDATA_FAULT = 32'hDEAD_BEEF;

    // Replace byte lane i of old with the matching lane of wdata wherever wstrb[i] is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = old;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_responder_word_ram.sv
// Single-port word RAM: combinational read, byte-lane write on clk.
module word_ram
    import mem_pkg::*;
#(
    parameter int WORDS     = 1024,
    parameter     INIT_FILE = "",
    parameter int AW        = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wstrb,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Byte-enable write of the addressed word
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed RAM answering a picorv32-style valid/ready bus after LATENCY cycles.
// Build option: MEM_RESP_FAULT_EN adds the mem_fault port and returns DEAD_BEEF on
// out-of-range reads; without it out-of-range reads return zero.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          WORDS     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter              INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
`ifdef MEM_RESP_FAULT_EN
    output logic        mem_fault,
`endif
    output logic [31:0] mem_rdata
);

    localparam int AW = $clog2(WORDS);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
`ifdef MEM_RESP_FAULT_EN
    localparam logic [31:0] OOR_RDATA = OOR_RDATA_FAULT;
`else
    localparam logic [31:0] OOR_RDATA = 32'h0000_0000;
`endif

    resp_state_t   state, next_state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    wstrb_q;
    logic          in_range_q;

    logic [31:0]   req_addr, req_wdata, off;
    logic [3:0]    req_wstrb;
    logic          req_in_range, enter_resp, ram_we, fault_int;
    logic [31:0]   ram_rdata;

    // In IDLE the request is taken straight from the bus so LATENCY==1 can commit
    // on the accept edge; otherwise the latched copy is used.
    assign req_addr     = (state == IDLE) ? mem_addr  : addr_q;
    assign req_wdata    = (state == IDLE) ? mem_wdata : wdata_q;
    assign req_wstrb    = (state == IDLE) ? mem_wstrb : wstrb_q;
    assign off          = req_addr - BASE_ADDR;
    assign req_in_range = (req_addr >= BASE_ADDR) && ((off >> 2) < 32'(WORDS));
    assign enter_resp   = (next_state == RESP) && (state != RESP);
    assign ram_we       = enter_resp && req_in_range && !reset && (|req_wstrb);

    word_ram #(.WORDS(WORDS), .INIT_FILE(INIT_FILE), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .wstrb (req_wstrb),
        .idx   (off[AW+1:2]),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (mem_valid) next_state = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        mem_ready = (state == RESP);
        fault_int = (state == RESP) && !in_range_q;
    end

    // Wait-state counter: loaded on accept, counts down in WAIT
    always_ff @(posedge clk) begin
        if (reset)                           cnt <= '0;
        else if (state == IDLE && mem_valid) cnt <= CW'((LATENCY >= 2) ? LATENCY - 2 : 0);
        else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end

    // Request latch, captured on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            in_range_q <= 1'b0;
        end else if (state == IDLE && mem_valid) begin
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            wstrb_q    <= mem_wstrb;
            in_range_q <= req_in_range;
        end
    end

    // Read data sampled before the write on the edge that enters RESP, held otherwise
    always_ff @(posedge clk) begin
        if (reset)           mem_rdata <= '0;
        else if (enter_resp) mem_rdata <= req_in_range ? ram_rdata : OOR_RDATA;
    end

`ifdef MEM_RESP_FAULT_EN
    assign mem_fault = fault_int;
    logic unused_bits;
    assign unused_bits = ^{mem_instr, off[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{mem_instr, off[1:0], fault_int};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver queues expected responses, a monitor
// checks each mem_ready pulse for latency, read data and fault.
module tb_mem_responder;

    localparam int          WORDS   = 16;
    localparam int          LATENCY = 3;
    localparam logic [31:0] BASE    = 32'h0000_0100;
`ifdef MEM_RESP_FAULT_EN
    localparam logic [31:0] OOR_VAL = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] OOR_VAL = 32'h0000_0000;
`endif

    typedef struct {
        logic        chk;
        logic [31:0] rdata;
        logic        fault;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
`ifdef MEM_RESP_FAULT_EN
    logic        mem_fault;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_ready = 1'b0;
    exp_t sb[$];

    mem_responder #(.WORDS(WORDS), .LATENCY(LATENCY), .BASE_ADDR(BASE), .INIT_FILE("")) u_dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
`ifdef MEM_RESP_FAULT_EN
        .mem_fault (mem_fault),
`endif
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ready pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (mem_ready === 1'b1) begin
            checks++;
            if (prev_ready) begin
                errors++;
                $display("FAIL pulse_width: ready high two cycles running at cyc %0d", cyc);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: ready at cyc %0d with no request pending", cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (cyc - e.start != LATENCY) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles, want %0d", cyc - e.start, LATENCY);
                end
                if (e.chk) begin
                    checks++;
                    if (mem_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata: got %08h, want %08h", mem_rdata, e.rdata);
                    end
                end
`ifdef MEM_RESP_FAULT_EN
                checks++;
                if (mem_fault !== e.fault) begin
                    errors++;
                    $display("FAIL fault: got %0b, want %0b", mem_fault, e.fault);
                end
`endif
            end
        end
        prev_ready = (mem_ready === 1'b1);
    end

    // One bus transaction; abort_rst resets the DUT mid-wait, drop_early releases valid in WAIT
    task automatic req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic chk, input logic [31:0] exp_rd, input logic exp_fault,
                       input logic abort_rst, input logic drop_early);
        int n;
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        if (abort_rst) begin
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            reset     = 1'b0;
            mem_valid = 1'b0;
            mem_wstrb = 4'b0000;
            checks++;
            if (mem_ready !== 1'b0) begin
                errors++;
                $display("FAIL abort_ready: got %0b, want 0", mem_ready);
            end
            repeat (6) @(posedge clk);
            return;
        end
        sb.push_back('{chk, exp_rd, exp_fault, cyc});
        if (drop_early) begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
        end
        n = 0;
        while (mem_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL timeout: no ready for addr %08h", addr);
            void'(sb.pop_front());
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd, input logic oor);
        req(addr, 32'h0, 4'b0000, 1'b1, exp_rd, oor, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic chk, input logic [31:0] old_rd, input logic oor);
        req(addr, wdata, wstrb, chk, old_rd, oor, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b, want 0", mem_ready); end
        checks++;
        if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %08h, want 0", mem_rdata); end
`ifdef MEM_RESP_FAULT_EN
        checks++;
        if (mem_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b, want 0", mem_fault); end
`endif
        reset = 1'b0;

        // Basic store/load, including a nonzero base offset
        wr(32'h100, 32'h0000_0013, 4'hF, 1'b0, 32'h0, 1'b0);
        rd(32'h100, 32'h0000_0013, 1'b0);
        wr(32'h110, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0);
        rd(32'h110, 32'hCAFE_F00D, 1'b0);
        rd(32'h113, 32'hCAFE_F00D, 1'b0);

        // rdata holds between responses
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rdata_hold: got %08h, want cafef00d", mem_rdata);
        end

        // Byte and halfword stores; the store response carries the pre-write word
        wr(32'h120, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0);
        wr(32'h122, 32'hAAAA_AAAA, 4'b0100, 1'b1, 32'h1122_3344, 1'b0);
        rd(32'h120, 32'h11AA_3344, 1'b0);
        wr(32'h122, 32'hBEEF_BEEF, 4'b1100, 1'b1, 32'h11AA_3344, 1'b0);
        rd(32'h120, 32'hBEEF_3344, 1'b0);

        // Out of range: one past the top, and below the base
        wr(32'h13C, 32'h7777_7777, 4'hF, 1'b0, 32'h0, 1'b0);
        rd(32'h140, OOR_VAL, 1'b1);
        rd(32'h0FC, OOR_VAL, 1'b1);
        wr(32'h140, 32'h9999_9999, 4'hF, 1'b1, OOR_VAL, 1'b1);
        wr(32'h0FC, 32'h6666_6666, 4'hF, 1'b1, OOR_VAL, 1'b1);
        rd(32'h100, 32'h0000_0013, 1'b0);
        rd(32'h13C, 32'h7777_7777, 1'b0);

        // Reset during WAIT abandons the store
        wr(32'h108, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0);
        req(32'h108, 32'h5555_5555, 4'hF, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rd(32'h108, 32'h1234_5678, 1'b0);

        // valid dropped during WAIT still completes
        req(32'h110, 32'h0, 4'b0000, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        rd(32'h120, 32'hBEEF_3344, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
